poly_mult_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares one GF(2^4) polynomial multiplier core (load/done handshake, 4-bit operands) among NREQ requesters in the AES datapath. It accepts one request at a time, loads the operands into the core and waits for done. It then returns the result to the owning requester. A watchdog aborts and resets the core if done never arrives.

---
 rtl/poly_mult_arbiter.sv | 203 ++++++++++++++++++++
 tb/tb_poly_mult_arbiter.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/poly_mult_arbiter.sv
// poly_mult_arbiter: round-robin sharing of one GF(2^4) multiplier core among NREQ requesters.
// Latency: req->gnt 1 cycle, gnt->mul_load 1 cycle, done rising edge->rsp_valid 2 cycles.
// Backpressure: requests sampled only in IDLE; POLY_ARB_ZERO_BYPASS_EN answers zero operands without the core.
module poly_mult_arbiter #(
    parameter int NREQ         = 4,
    parameter int TIMEOUT      = 64,
    parameter int ABORT_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [4*NREQ-1:0]    req_mpr,
    input  logic [4*NREQ-1:0]    req_mcd,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      rsp_valid,
    output logic [3:0]           rsp_data,
    output logic                 rsp_err,
    output logic                 busy,
    output logic                 mul_load,
    output logic [3:0]           mul_multiplier,
    output logic [3:0]           mul_multiplicand,
    output logic                 mul_n_reset,
    input  logic                 mul_done,
    input  logic [3:0]           mul_result
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int TW = $clog2(TIMEOUT);
    localparam int AW = $clog2(ABORT_CYCLES + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_WAIT,
        S_RESP,
        S_ABORT
    } state_t;

    state_t          state_q, state_d;
    logic [IW-1:0]   ptr_q, ptr_d;
    logic [IW-1:0]   owner_q, owner_d;
    logic [IW-1:0]   sel_idx;
    logic            sel_found;
    logic [TW-1:0]   timer_q, timer_d;
    logic [AW-1:0]   abort_cnt_q, abort_cnt_d;
    logic            done_q;
    logic            done_edge;
    logic [3:0]      result_q, result_d;
    logic [NREQ-1:0] gnt_d, rsp_valid_d;
    logic [3:0]      rsp_data_d, mpr_d, mcd_d;
    logic            rsp_err_d, busy_d, mul_load_d, mul_n_reset_d;
    logic [3:0]      mpr_arr [NREQ];
    logic [3:0]      mcd_arr [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_unpack
        assign mpr_arr[g] = req_mpr[4*g +: 4];
        assign mcd_arr[g] = req_mcd[4*g +: 4];
    end

    function automatic logic [NREQ-1:0] onehot(input logic [IW-1:0] i);
        logic [NREQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    // Search starts just after the last owner, so the last served requester ranks lowest.
    always_comb begin
        int cand;
        cand      = 0;
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            cand = int'(ptr_q) + k;
            if (cand >= NREQ) begin
                cand = cand - NREQ;
            end
            if (!sel_found && req[IW'(cand)]) begin
                sel_found = 1'b1;
                sel_idx   = IW'(cand);
            end
        end
    end

    // A done level left over from the previous op must not complete this one.
    assign done_edge = mul_done && !done_q;

    always_comb begin
        state_d       = state_q;
        ptr_d         = ptr_q;
        owner_d       = owner_q;
        timer_d       = timer_q;
        abort_cnt_d   = abort_cnt_q;
        result_d      = result_q;
        gnt_d         = '0;
        rsp_valid_d   = '0;
        rsp_data_d    = '0;
        rsp_err_d     = 1'b0;
        mul_load_d    = 1'b0;
        mpr_d         = mul_multiplier;
        mcd_d         = mul_multiplicand;
        mul_n_reset_d = 1'b1;

        case (state_q)
            S_IDLE: begin
                if (sel_found) begin
                    gnt_d   = onehot(sel_idx);
                    owner_d = sel_idx;
                    mpr_d   = mpr_arr[sel_idx];
                    mcd_d   = mcd_arr[sel_idx];
`ifdef POLY_ARB_ZERO_BYPASS_EN
                    if ((mpr_arr[sel_idx] == 4'h0) || (mcd_arr[sel_idx] == 4'h0)) begin
                        result_d = 4'h0;
                        state_d  = S_RESP;
                    end else begin
                        state_d  = S_LOAD;
                    end
`else
                    state_d = S_LOAD;
`endif
                end
            end
            S_LOAD: begin
                mul_load_d = 1'b1;
                timer_d    = '0;
                state_d    = S_WAIT;
            end
            S_WAIT: begin
                if (done_edge) begin
                    result_d = mul_result;
                    state_d  = S_RESP;
                end else if (timer_q == TW'(TIMEOUT - 1)) begin
                    abort_cnt_d   = '0;
                    mul_n_reset_d = 1'b0;
                    state_d       = S_ABORT;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            S_RESP: begin
                rsp_valid_d = onehot(owner_q);
                rsp_data_d  = result_q;
                ptr_d       = owner_q;
                state_d     = S_IDLE;
            end
            S_ABORT: begin
                if (abort_cnt_q == AW'(ABORT_CYCLES - 1)) begin
                    rsp_valid_d = onehot(owner_q);
                    rsp_err_d   = 1'b1;
                    ptr_d       = owner_q;
                    state_d     = S_IDLE;
                end else begin
                    mul_n_reset_d = 1'b0;
                    abort_cnt_d   = abort_cnt_q + AW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q          <= S_IDLE;
            ptr_q            <= IW'(NREQ - 1);
            owner_q          <= '0;
            timer_q          <= '0;
            abort_cnt_q      <= '0;
            done_q           <= 1'b0;
            result_q         <= '0;
            gnt              <= '0;
            rsp_valid        <= '0;
            rsp_data         <= '0;
            rsp_err          <= 1'b0;
            busy             <= 1'b0;
            mul_load         <= 1'b0;
            mul_multiplier   <= '0;
            mul_multiplicand <= '0;
            mul_n_reset      <= 1'b1;
        end else begin
            state_q          <= state_d;
            ptr_q            <= ptr_d;
            owner_q          <= owner_d;
            timer_q          <= timer_d;
            abort_cnt_q      <= abort_cnt_d;
            done_q           <= mul_done;
            result_q         <= result_d;
            gnt              <= gnt_d;
            rsp_valid        <= rsp_valid_d;
            rsp_data         <= rsp_data_d;
            rsp_err          <= rsp_err_d;
            busy             <= busy_d;
            mul_load         <= mul_load_d;
            mul_multiplier   <= mpr_d;
            mul_multiplicand <= mcd_d;
            mul_n_reset      <= mul_n_reset_d;
        end
    end

endmodule

// File: tb/tb_poly_mult_arbiter.sv
// Directed bench for poly_mult_arbiter with a behavioural GF(2^4) core (x^4+x+1).
module tb_poly_mult_arbiter;

`ifdef POLY_ARB_ZERO_BYPASS_EN
    localparam int BYP_RSP_CYC = 1;
    localparam int BYP_LOADS   = 0;
`else
    localparam int BYP_RSP_CYC = 10;
    localparam int BYP_LOADS   = 1;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  req = '0;
    logic [15:0] req_mpr = '0;
    logic [15:0] req_mcd = '0;
    logic [3:0]  gnt, rsp_valid, rsp_data;
    logic        rsp_err, busy, mul_load, mul_n_reset;
    logic [3:0]  mul_multiplier, mul_multiplicand;
    logic        mul_done = 1'b0;
    logic [3:0]  mul_result = '0;

    int   n_cmp = 0;
    int   n_err = 0;
    int   core_lat = 6;
    logic core_dead = 1'b0;
    int   core_cnt = 0;
    logic core_pend = 1'b0;
    logic [3:0] core_res = '0;
    int   n_load = 0;
    int   n_nrst_low = 0;
    int   n_multi = 0;

    always #5 clk = ~clk;

    poly_mult_arbiter #(.NREQ(4), .TIMEOUT(64), .ABORT_CYCLES(2)) dut (
        .clk              (clk),
        .reset            (reset),
        .req              (req),
        .req_mpr          (req_mpr),
        .req_mcd          (req_mcd),
        .gnt              (gnt),
        .rsp_valid        (rsp_valid),
        .rsp_data         (rsp_data),
        .rsp_err          (rsp_err),
        .busy             (busy),
        .mul_load         (mul_load),
        .mul_multiplier   (mul_multiplier),
        .mul_multiplicand (mul_multiplicand),
        .mul_n_reset      (mul_n_reset),
        .mul_done         (mul_done),
        .mul_result       (mul_result)
    );

    function automatic logic [3:0] gf_mul(input logic [3:0] a, input logic [3:0] b);
        logic [3:0] p;
        logic [3:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 4; i++) begin
            if (b[i]) p = p ^ x;
            x = x[3] ? ((x << 1) ^ 4'h3) : (x << 1);
        end
        return p;
    endfunction

    // Core: keeps a previous done high for one cycle after load, then raises done core_lat cycles after load.
    always @(posedge clk) begin
        if (!mul_n_reset) begin
            core_pend <= 1'b0;
            core_cnt  <= 0;
            mul_done  <= 1'b0;
        end else if (mul_load) begin
            core_pend <= 1'b1;
            core_cnt  <= 0;
            core_res  <= gf_mul(mul_multiplier, mul_multiplicand);
        end else if (core_pend) begin
            core_cnt <= core_cnt + 1;
            if (core_cnt + 1 == 1) mul_done <= 1'b0;
            if (core_cnt + 1 == core_lat && !core_dead) begin
                mul_done   <= 1'b1;
                mul_result <= core_res;
                core_pend  <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (mul_load === 1'b1) n_load++;
        if (mul_n_reset === 1'b0) n_nrst_low++;
        if ($countones(gnt) > 1 || $countones(rsp_valid) > 1) n_multi++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // which: 0 = gnt, 1 = mul_load, 2 = rsp_valid; returns max+1 when nothing arrived.
    task automatic wait_for(input int which, input int max, output int cyc);
        logic hit;
        hit = 1'b0;
        cyc = 0;
        while (!hit && cyc < max) begin
            @(negedge clk);
            cyc++;
            case (which)
                0:       hit = (gnt != 4'b0000);
                1:       hit = (mul_load === 1'b1);
                default: hit = (rsp_valid != 4'b0000);
            endcase
        end
        if (!hit) cyc = max + 1;
    endtask

    initial begin
        int cyc;
        int l0;
        int nr0;
        logic [3:0] rr_exp [5];
        logic [3:0] rr_dat [5];
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        rr_dat = '{4'h1, 4'h9, 4'h9, 4'h9, 4'h1};

        @(negedge clk);
        chk("reset_outputs", {gnt, rsp_valid, rsp_data, rsp_err, busy, mul_load, mul_n_reset,
                              mul_multiplier, mul_multiplicand}, 24'h000100);
        reset = 1'b0;

        // Single request: 3*7 = 9
        req_mpr = 16'h0003; req_mcd = 16'h0007; req = 4'b0001; core_lat = 6;
        l0 = n_load;
        wait_for(0, 10, cyc);
        chk("single_gnt_lat", cyc, 1);
        chk("single_gnt", gnt, 4'b0001);
        chk("single_ops", {mul_multiplier, mul_multiplicand}, 8'h37);
        chk("single_busy", busy, 1);
        req = 4'b0000;
        wait_for(1, 10, cyc);
        chk("single_load_lat", cyc, 1);
        chk("single_gnt_pulse", gnt, 4'b0000);
        wait_for(2, 20, cyc);
        chk("single_rsp_lat", cyc, 9);
        chk("single_rsp_owner", rsp_valid, 4'b0001);
        chk("single_rsp_data", rsp_data, 4'h9);
        chk("single_rsp_err", rsp_err, 0);
        chk("single_idle_busy", busy, 0);
        chk("single_load_cnt", n_load - l0, 1);

        // Stale done: core still shows done from the previous op; 1*5 = 5
        req_mpr = 16'h0100; req_mcd = 16'h0500; req = 4'b0100; core_lat = 4;
        wait_for(0, 10, cyc);
        chk("stale_gnt", gnt, 4'b0100);
        req = 4'b0000;
        wait_for(1, 10, cyc);
        chk("stale_load_lat", cyc, 1);
        wait_for(2, 20, cyc);
        chk("stale_rsp_lat", cyc, 7);
        chk("stale_rsp_owner", rsp_valid, 4'b0100);
        chk("stale_rsp_data", rsp_data, 4'h5);

        // Timeout: core never answers
        req_mpr = 16'h3000; req_mcd = 16'h7000; req = 4'b1000; core_dead = 1'b1;
        nr0 = n_nrst_low;
        wait_for(0, 10, cyc);
        chk("tmo_gnt", gnt, 4'b1000);
        req = 4'b0000;
        wait_for(1, 10, cyc);
        chk("tmo_load_lat", cyc, 1);
        wait_for(2, 100, cyc);
        chk("tmo_rsp_lat", cyc, 66);
        chk("tmo_rsp_owner", rsp_valid, 4'b1000);
        chk("tmo_rsp_err", rsp_err, 1);
        chk("tmo_rsp_data", rsp_data, 4'h0);
        chk("tmo_nrst_back", mul_n_reset, 1);
        chk("tmo_nrst_cycles", n_nrst_low - nr0, 2);

        // Recovery after abort: 2*9 = 1
        core_dead = 1'b0; core_lat = 6;
        req_mpr = 16'h0002; req_mcd = 16'h0009; req = 4'b0001;
        wait_for(0, 10, cyc);
        chk("recov_gnt", gnt, 4'b0001);
        req = 4'b0000;
        wait_for(2, 20, cyc);
        chk("recov_rsp_lat", cyc, 10);
        chk("recov_rsp_data", rsp_data, 4'h1);
        chk("recov_rsp_err", rsp_err, 0);

        // Round-robin from reset with all requests held
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        req_mpr = 16'h3332; req_mcd = 16'h7779; req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_for(0, 10, cyc);
            chk("rr_gnt_lat", cyc, 1);
            chk("rr_gnt", gnt, rr_exp[i]);
            wait_for(2, 20, cyc);
            chk("rr_rsp_owner", rsp_valid, rr_exp[i]);
            chk("rr_rsp_data", rsp_data, rr_dat[i]);
        end
        req = 4'b0000;

        // Reset in the middle of WAIT
        req = 4'b0010;
        wait_for(0, 10, cyc);
        chk("midop_gnt", gnt, 4'b0010);
        req = 4'b0000;
        wait_for(1, 10, cyc);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        #1;
        chk("midop_reset_outputs", {gnt, rsp_valid, rsp_data, rsp_err, busy, mul_load, mul_n_reset,
                                    mul_multiplier, mul_multiplicand}, 24'h000100);
        @(negedge clk);
        reset = 1'b0;
        wait_for(2, 15, cyc);
        chk("midop_no_rsp", cyc, 16);
        req = 4'b1111;
        wait_for(0, 10, cyc);
        chk("post_reset_gnt", gnt, 4'b0001);
        req = 4'b0000;
        wait_for(2, 20, cyc);
        chk("post_reset_rsp_owner", rsp_valid, 4'b0001);
        chk("post_reset_rsp_data", rsp_data, 4'h1);

        // Zero operand: mpr=0, mcd=B on requester 1
        req_mpr = 16'h0002; req_mcd = 16'h00B9; req = 4'b0010;
        l0 = n_load;
        wait_for(0, 10, cyc);
        chk("zero_gnt", gnt, 4'b0010);
        req = 4'b0000;
        wait_for(2, 20, cyc);
        chk("zero_rsp_lat", cyc, BYP_RSP_CYC);
        chk("zero_rsp_owner", rsp_valid, 4'b0010);
        chk("zero_rsp_data", rsp_data, 4'h0);
        chk("zero_rsp_err", rsp_err, 0);
        @(negedge clk);
        chk("zero_load_cnt", n_load - l0, BYP_LOADS);

        chk("multi_hot_pulses", n_multi, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
